video_out_fetch: RTL and testbench
==================================

Name: video_out_fetch

Overview:
- Wishbone master that reads a stored frame back out of RAM and pushes it into the video output FIFO. It is the read-side counterpart of the video input store path.
- The processor writes a frame base address through a wishbone register. The block then fetches the whole frame in packs of NB_PACK 32-bit words, each word holding 4 pixels of 8 bits.
- It raises a one-cycle interrupt when the frame has been fully read.

Parameters:
- p_WIDTH, 640: pixels per line.
- p_HEIGHT, 480: lines per frame.
- NB_PACK, 16: words fetched per pack (one CYC burst). p_WIDTH*p_HEIGHT/4 must be a multiple of NB_PACK.

Ports:
- clk  in  1: clock; all logic on rising edge.
- RST  in  1: synchronous reset, active-high.
- wb_reg_addr  in  32: frame base byte address from processor register.
- wb_reg_valid  in  1: a rising edge means a new base address has been written.
- fifo_space  in  16: free word slots in the output FIFO.
- fifo_data  out  32: word pushed to the FIFO.
- fifo_we  out  1: FIFO write strobe, one cycle per word.
- interrupt  out  1: one-cycle pulse at end of frame.
- err  out  1: sticky bus-error flag.
- p_wb_STB_O  out  1: wishbone strobe.
- p_wb_CYC_O  out  1: wishbone cycle.
- p_wb_LOCK_O  out  1: constant 0.
- p_wb_SEL_O  out  4: constant 4'hF.
- p_wb_WE_O  out  1: constant 0 (read only).
- p_wb_ADR_O  out  32: word byte address.
- p_wb_DAT_I  in  32: read data.
- p_wb_ACK_I  in  1: transfer acknowledge.
- p_wb_ERR_I  in  1: transfer error.

Behaviour:
- Reset (RST=1 at an edge; overrides everything, including mid-burst):
  - STB, CYC, fifo_we, interrupt, err, pending = 0.
  - ADR, fifo_data, counters = 0.
  - State = WAIT_ADDR.
  - Internal wb_reg_valid history register = 0.
- Address event: new_addr = wb_reg_valid & ~valid_q, with valid_q registered each cycle.
  - In WAIT_ADDR, new_addr is consumed directly.
  - In any other state it sets pending=1, which is consumed on the next entry to WAIT_ADDR.
- Constants: WORDS = p_WIDTH*p_HEIGHT/4. word_cnt is a 17-bit counter 0..WORDS-1. pack_cnt counts 0..NB_PACK-1.
- WAIT_ADDR: STB=CYC=0.
  - On new_addr or pending: latch base=wb_reg_addr, clear err, pending, word_cnt, pack_cnt.
  - Go to WAIT_SPACE.
- WAIT_SPACE: STB=CYC=0.
  - When fifo_space >= NB_PACK: drive ADR = base + 4*word_cnt, STB=CYC=1 (registered), go to READ.
- READ: STB and CYC held until the slave responds. ADR is stable while STB=1 and ACK_I=0.
  - ACK_I=1 (ERR_I=0):
    - Next cycle: fifo_data = DAT_I, fifo_we = 1 for exactly one cycle.
    - word_cnt+1, pack_cnt+1.
  - Pack not finished: STB and CYC stay 1 and ADR advances by 4 at the same edge. Back-to-back zero-wait acks give one word per cycle.
  - Last word of the pack, frame not finished: STB=CYC=0, go to WAIT_SPACE.
  - Last word of the frame (word_cnt = WORDS-1): STB=CYC=0, go to DONE.
- DONE: interrupt = 1 for one cycle, then go to WAIT_ADDR.
- ERR_I=1 while STB=1 (ERR wins over a simultaneous ACK):
  - Word discarded, no fifo_we.
  - STB=CYC=0 next cycle, err=1, go to WAIT_ADDR, no interrupt.
  - err stays set until the next address is accepted.
- ACK_I or ERR_I while STB=0: ignored.
- fifo_space is checked only before each pack. Within a pack, the FIFO is guaranteed not to overflow.
- Address arithmetic is mod 2^32; wrap-around is not flagged.

Test Plan:
1. Reset check: RST=1 for 2 cycles with the bus idle.
   -> All outputs 0, SEL_O=4'hF, WE_O=0, LOCK_O=0.
2. Basic frame: p_WIDTH=8, p_HEIGHT=2, NB_PACK=2 (4 words); base 0x00001000; fifo_space=8; zero-wait slave returning data = address.
   -> ADR sequence 0x1000, 0x1004, CYC drop, 0x1008, 0x100C.
   -> Four fifo_we pulses carrying those values.
   -> interrupt high exactly one cycle, after the last fifo_we.
3. FIFO backpressure: fifo_space=1 after the address is written.
   -> CYC stays 0 for 20 cycles.
   -> Set fifo_space=2: CYC rises within 2 cycles, pack of 2 fetched.
4. Wait states: slave delays ACK by 3 cycles per word.
   -> ADR and STB stable throughout the wait.
   -> Exactly one fifo_we per ACK, with correct data.
5. Bus error: ERR_I on the 2nd word of frame 1.
   -> Only 1 fifo_we, err=1, CYC=0 next cycle, no interrupt.
   -> A new address clears err and restarts at word 0.
6. Pending address and reset: new address 0x2000 written mid-frame.
   -> Frame 1 completes with interrupt, frame 2 starts at 0x2000 with no further processor write.
   -> RST asserted mid-burst of frame 2: CYC=0 next edge, and no fetch until a new address is written.

Source files
------------

// File: rtl/video_out_fetch.sv
// video_out_fetch: wishbone master reading a stored frame from RAM into the video output FIFO
module video_out_fetch #(
   parameter int p_WIDTH  = 640,
   parameter int p_HEIGHT = 480,
   parameter int NB_PACK  = 16
)(
   input  logic        clk,
   input  logic        RST,
   input  logic [31:0] wb_reg_addr,
   input  logic        wb_reg_valid,
   input  logic [15:0] fifo_space,
   output logic [31:0] fifo_data,
   output logic        fifo_we,
   output logic        interrupt,
   output logic        err,
   output logic        p_wb_STB_O,
   output logic        p_wb_CYC_O,
   output logic        p_wb_LOCK_O,
   output logic [3:0]  p_wb_SEL_O,
   output logic        p_wb_WE_O,
   output logic [31:0] p_wb_ADR_O,
   input  logic [31:0] p_wb_DAT_I,
   input  logic        p_wb_ACK_I,
   input  logic        p_wb_ERR_I
);
   localparam int WORDS = p_WIDTH * p_HEIGHT / 4;
   localparam int PW    = NB_PACK > 1 ? $clog2(NB_PACK) : 1;

   typedef enum logic [1:0] {WAIT_ADDR, WAIT_SPACE, READ, DONE} state_t;

   state_t        r_state, w_state_next;
   logic          r_valid_q, r_pending, r_stb, r_we, r_irq, r_err;
   logic [31:0]   r_base, r_adr, r_data;
   logic [16:0]   r_word_cnt;
   logic [PW-1:0] r_pack_cnt;
   logic          w_new_addr, w_start, w_space_ok, w_ack, w_bus_err, w_last_word, w_last_pack;

   assign w_new_addr  = wb_reg_valid & ~r_valid_q;
   assign w_start     = (r_state == WAIT_ADDR) && (w_new_addr || r_pending);
   assign w_space_ok  = fifo_space >= 16'(NB_PACK);
   assign w_bus_err   = (r_state == READ) && r_stb && p_wb_ERR_I;
   assign w_ack       = (r_state == READ) && r_stb && p_wb_ACK_I && !p_wb_ERR_I;
   assign w_last_word = r_word_cnt == 17'(WORDS - 1);
   assign w_last_pack = r_pack_cnt == PW'(NB_PACK - 1);

   assign fifo_data   = r_data;
   assign fifo_we     = r_we;
   assign interrupt   = r_irq;
   assign err         = r_err;
   assign p_wb_STB_O  = r_stb;
   assign p_wb_CYC_O  = r_stb;
   assign p_wb_LOCK_O = 1'b0;
   assign p_wb_SEL_O  = 4'hF;
   assign p_wb_WE_O   = 1'b0;
   assign p_wb_ADR_O  = r_adr;

   // state register
   always_ff @(posedge clk)
      r_state <= RST ? WAIT_ADDR : w_state_next;

   // next-state: an error aborts the frame, the last word ends it, a full pack re-checks FIFO space
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         WAIT_ADDR:  w_state_next = w_start ? WAIT_SPACE : WAIT_ADDR;
         WAIT_SPACE: w_state_next = w_space_ok ? READ : WAIT_SPACE;
         READ:       w_state_next = w_bus_err ? WAIT_ADDR :
                                    !w_ack ? READ :
                                    w_last_word ? DONE :
                                    w_last_pack ? WAIT_SPACE : READ;
         default:    w_state_next = WAIT_ADDR;
      endcase
   end

   // datapath: address capture, bus strobe, counters, FIFO push and status flags
   always_ff @(posedge clk) begin
      if (RST) begin
         r_valid_q  <= 1'b0;
         r_pending  <= 1'b0;
         r_stb      <= 1'b0;
         r_we       <= 1'b0;
         r_irq      <= 1'b0;
         r_err      <= 1'b0;
         r_base     <= '0;
         r_adr      <= '0;
         r_data     <= '0;
         r_word_cnt <= '0;
         r_pack_cnt <= '0;
      end else begin
         r_valid_q <= wb_reg_valid;
         r_we      <= 1'b0;
         r_irq     <= r_state == DONE;
         if (w_new_addr && r_state != WAIT_ADDR)
            r_pending <= 1'b1;
         if (w_start) begin
            r_base     <= wb_reg_addr;
            r_err      <= 1'b0;
            r_pending  <= 1'b0;
            r_word_cnt <= '0;
            r_pack_cnt <= '0;
         end
         if (r_state == WAIT_SPACE && w_space_ok) begin
            r_adr <= r_base + {13'd0, r_word_cnt, 2'b00};
            r_stb <= 1'b1;
         end
         if (w_bus_err) begin
            r_stb <= 1'b0;
            r_err <= 1'b1;
         end else if (w_ack) begin
            r_data     <= p_wb_DAT_I;
            r_we       <= 1'b1;
            r_word_cnt <= r_word_cnt + 17'd1;
            r_pack_cnt <= w_last_pack ? '0 : r_pack_cnt + PW'(1);
            if (w_last_word || w_last_pack)
               r_stb <= 1'b0;
            else
               r_adr <= r_adr + 32'd4;
         end
      end
   end
endmodule

// File: tb/tb_video_out_fetch.sv
// tb_video_out_fetch: directed scenarios for the frame fetch master with a small wishbone slave
module tb_video_out_fetch;
   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] wb_reg_addr = '0;
   logic        wb_reg_valid = 1'b0;
   logic [15:0] fifo_space = 16'd8;
   logic [31:0] fifo_data;
   logic        fifo_we, interrupt, err;
   logic        stb, cyc_o, lock_o, we_o;
   logic [3:0]  sel_o;
   logic [31:0] adr;
   logic        ack_raw, err_i;

   int          passed = 0;
   int          total = 0;
   int          cyc = 0;
   int          wait_cfg = 0;
   int          r_w = 0;
   bit          err_en = 1'b0;
   logic [31:0] err_adr = '0;

   logic [31:0] ack_q[$];
   logic [31:0] data_q[$];
   int          irq_cnt = 0, irq_cyc = 0, last_we_cyc = 0, cyc_rise = 0, stab_viol = 0, stb_cycles = 0;
   logic        prev_stb = 1'b0, prev_done = 1'b0, prev_cyc = 1'b0;
   logic [31:0] prev_adr = '0;

   video_out_fetch #(.p_WIDTH(8), .p_HEIGHT(2), .NB_PACK(2)) dut (
      .clk(clk), .RST(RST),
      .wb_reg_addr(wb_reg_addr), .wb_reg_valid(wb_reg_valid), .fifo_space(fifo_space),
      .fifo_data(fifo_data), .fifo_we(fifo_we), .interrupt(interrupt), .err(err),
      .p_wb_STB_O(stb), .p_wb_CYC_O(cyc_o), .p_wb_LOCK_O(lock_o), .p_wb_SEL_O(sel_o),
      .p_wb_WE_O(we_o), .p_wb_ADR_O(adr), .p_wb_DAT_I(adr),
      .p_wb_ACK_I(ack_raw), .p_wb_ERR_I(err_i)
   );

   always #5 clk = ~clk;

   assign ack_raw = stb && (r_w == wait_cfg);
   assign err_i   = ack_raw && err_en && (adr == err_adr);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      r_w <= (!stb || ack_raw) ? 0 : r_w + 1;
   end

   always @(negedge clk) begin
      if (ack_raw && !err_i) ack_q.push_back(adr);
      if (fifo_we) begin
         data_q.push_back(fifo_data);
         last_we_cyc = cyc;
      end
      if (interrupt) begin
         irq_cnt++;
         irq_cyc = cyc;
      end
      if (cyc_o && !prev_cyc) cyc_rise++;
      if (stb) stb_cycles++;
      if (prev_stb && !prev_done && !RST && (!stb || adr != prev_adr)) stab_viol++;
      prev_stb  = stb;
      prev_done = ack_raw || err_i;
      prev_adr  = adr;
      prev_cyc  = cyc_o;
   end

   task automatic clear_mon();
      ack_q.delete();
      data_q.delete();
      irq_cnt = 0;
      cyc_rise = 0;
      stab_viol = 0;
      stb_cycles = 0;
   endtask

   task automatic write_addr(input logic [31:0] a);
      @(negedge clk);
      wb_reg_addr  = a;
      wb_reg_valid = 1'b1;
      @(negedge clk);
      wb_reg_valid = 1'b0;
   endtask

   task automatic wait_irq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (irq_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({stb, cyc_o, fifo_we, interrupt, err, we_o, lock_o} !== 7'b0) $display("FAIL reset_ctrl got %b want 0000000", {stb, cyc_o, fifo_we, interrupt, err, we_o, lock_o});
      else passed++;
      total++;
      if ({adr, fifo_data} !== 64'h0) $display("FAIL reset_data adr=%h data=%h want 0", adr, fifo_data);
      else passed++;
      total++;
      if (sel_o !== 4'hF) $display("FAIL reset_sel got %h want f", sel_o);
      else passed++;
      RST = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_frame();
      bit ok;
      wait_cfg = 0;
      fifo_space = 16'd8;
      clear_mon();
      write_addr(32'h1000);
      wait_irq(ok);
      repeat (4) @(negedge clk);
      total++;
      if (!ok) $display("FAIL basic_irq_timeout got none want pulse");
      else passed++;
      total++;
      if (ack_q.size() != 4 || {ack_q[0], ack_q[1], ack_q[2], ack_q[3]} !== {32'h1000, 32'h1004, 32'h1008, 32'h100C})
         $display("FAIL basic_adr n=%0d got %h %h %h %h want 1000 1004 1008 100c", ack_q.size(), ack_q[0], ack_q[1], ack_q[2], ack_q[3]);
      else passed++;
      total++;
      if (data_q.size() != 4 || {data_q[0], data_q[1], data_q[2], data_q[3]} !== {32'h1000, 32'h1004, 32'h1008, 32'h100C})
         $display("FAIL basic_data n=%0d got %h %h %h %h want 1000 1004 1008 100c", data_q.size(), data_q[0], data_q[1], data_q[2], data_q[3]);
      else passed++;
      total++;
      if (cyc_rise !== 2) $display("FAIL basic_cyc_bursts got %0d want 2", cyc_rise);
      else passed++;
      total++;
      if (irq_cnt !== 1 || irq_cyc != last_we_cyc + 1) $display("FAIL basic_irq cnt=%0d at=%0d want 1 at %0d", irq_cnt, irq_cyc, last_we_cyc + 1);
      else passed++;
   endtask

   task automatic test_backpressure();
      bit ok, saw;
      wait_cfg = 0;
      fifo_space = 16'd1;
      clear_mon();
      write_addr(32'h3000);
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (cyc_o) saw = 1'b1;
      end
      total++;
      if (saw) $display("FAIL bp_hold got cyc=1 want 0 for 20 cycles");
      else passed++;
      fifo_space = 16'd2;
      saw = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (cyc_o) saw = 1'b1;
      end
      total++;
      if (!saw) $display("FAIL bp_release got cyc=0 want 1 within 2 cycles");
      else passed++;
      wait_irq(ok);
      repeat (2) @(negedge clk);
      total++;
      if (!ok) $display("FAIL bp_irq_timeout got none want pulse");
      else passed++;
      total++;
      if (data_q.size() != 4 || {data_q[0], data_q[1], data_q[2], data_q[3]} !== {32'h3000, 32'h3004, 32'h3008, 32'h300C})
         $display("FAIL bp_data n=%0d got %h %h %h %h want 3000 3004 3008 300c", data_q.size(), data_q[0], data_q[1], data_q[2], data_q[3]);
      else passed++;
   endtask

   task automatic test_wait_states();
      bit ok;
      wait_cfg = 3;
      fifo_space = 16'd8;
      clear_mon();
      write_addr(32'h4000);
      wait_irq(ok);
      repeat (2) @(negedge clk);
      total++;
      if (!ok) $display("FAIL ws_irq_timeout got none want pulse");
      else passed++;
      total++;
      if (stab_viol !== 0) $display("FAIL ws_stable got %0d changes want 0", stab_viol);
      else passed++;
      total++;
      if (stb_cycles !== 16) $display("FAIL ws_stb_cycles got %0d want 16", stb_cycles);
      else passed++;
      total++;
      if (data_q.size() != 4 || {data_q[0], data_q[1], data_q[2], data_q[3]} !== {32'h4000, 32'h4004, 32'h4008, 32'h400C})
         $display("FAIL ws_data n=%0d got %h %h %h %h want 4000 4004 4008 400c", data_q.size(), data_q[0], data_q[1], data_q[2], data_q[3]);
      else passed++;
      wait_cfg = 0;
   endtask

   task automatic test_bus_error();
      bit ok;
      wait_cfg = 0;
      fifo_space = 16'd8;
      err_en = 1'b1;
      err_adr = 32'h5004;
      clear_mon();
      write_addr(32'h5000);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (err) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok || cyc_o !== 1'b0) $display("FAIL berr_flag err=%b cyc=%b want err=1 cyc=0", err, cyc_o);
      else passed++;
      repeat (10) @(negedge clk);
      total++;
      if (data_q.size() != 1 || data_q[0] !== 32'h5000) $display("FAIL berr_data n=%0d got %h want 1 word 5000", data_q.size(), data_q[0]);
      else passed++;
      total++;
      if (irq_cnt !== 0 || cyc_rise !== 1 || err !== 1'b1) $display("FAIL berr_idle irq=%0d bursts=%0d err=%b want 0 1 1", irq_cnt, cyc_rise, err);
      else passed++;
      err_en = 1'b0;
      clear_mon();
      write_addr(32'h6000);
      total++;
      if (err !== 1'b0) $display("FAIL berr_clear got %b want 0", err);
      else passed++;
      wait_irq(ok);
      repeat (2) @(negedge clk);
      total++;
      if (!ok || ack_q.size() != 4 || {ack_q[0], ack_q[1], ack_q[2], ack_q[3]} !== {32'h6000, 32'h6004, 32'h6008, 32'h600C})
         $display("FAIL berr_restart n=%0d got %h %h %h %h want 6000 6004 6008 600c", ack_q.size(), ack_q[0], ack_q[1], ack_q[2], ack_q[3]);
      else passed++;
   endtask

   task automatic test_pending_and_reset();
      bit ok, saw;
      int n;
      wait_cfg = 1;
      fifo_space = 16'd8;
      clear_mon();
      write_addr(32'h7000);
      for (int i = 0; i < 50 && ack_q.size() == 0; i++) @(negedge clk);
      write_addr(32'h2000);
      wait_irq(ok);
      total++;
      if (!ok || ack_q.size() != 4 || {ack_q[0], ack_q[1], ack_q[2], ack_q[3]} !== {32'h7000, 32'h7004, 32'h7008, 32'h700C})
         $display("FAIL pend_frame1 n=%0d got %h %h %h %h want 7000 7004 7008 700c", ack_q.size(), ack_q[0], ack_q[1], ack_q[2], ack_q[3]);
      else passed++;
      clear_mon();
      for (int i = 0; i < 50 && ack_q.size() == 0; i++) @(negedge clk);
      total++;
      if (ack_q.size() == 0 || ack_q[0] !== 32'h2000) $display("FAIL pend_frame2 n=%0d got %h want 2000", ack_q.size(), ack_q[0]);
      else passed++;
      total++;
      if (cyc_o !== 1'b1) $display("FAIL pend_midburst got cyc=%b want 1", cyc_o);
      else passed++;
      RST = 1'b1;
      @(negedge clk);
      total++;
      if (cyc_o !== 1'b0 || stb !== 1'b0) $display("FAIL rst_midburst cyc=%b stb=%b want 0 0", cyc_o, stb);
      else passed++;
      RST = 1'b0;
      n = data_q.size();
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (cyc_o) saw = 1'b1;
      end
      total++;
      if (saw || data_q.size() != n + 0 && data_q.size() > n) $display("FAIL rst_idle cyc_seen=%b words=%0d want 0 %0d", saw, data_q.size(), n);
      else passed++;
      total++;
      if (irq_cnt !== 0) $display("FAIL rst_no_irq got %0d want 0", irq_cnt);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_wait_states();
      test_bus_error();
      test_pending_and_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
